// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: mul/div opcodes, funct codes and mul/div FSM states.
package mips_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_e;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic op_is_signed(input muldiv_op_e op);
        return (op == MULT) || (op == DIV);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Core <-> mul/div unit connection: start/busy/done handshake plus HI/LO access.
interface mul_div_unit_if
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    logic             start;
    muldiv_op_e       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Works on magnitudes for WIDTH cycles, then fixes up signs in one final cycle.
module mul_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_width_check
        $error("mul_div_unit: WIDTH must be >= 4 and even");
    end

    muldiv_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    muldiv_op_e         op_q;
    logic [WIDTH-1:0]   opnd_q;     // multiplicand (mul) or divisor (div) magnitude
    logic [WIDTH-1:0]   work_q;     // multiplier shifting out, or dividend shifting into quotient
    logic [WIDTH:0]     acc_q;      // product high half, or working remainder
    logic               res_neg_q, rem_neg_q, b_zero_q;
    logic [WIDTH-1:0]   orig_a_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;
    logic               busy;

    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum, acc_step;
    logic [WIDTH+1:0]   rem_shift, diff;
    logic [WIDTH-1:0]   work_step;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;

    // Operand magnitudes for the incoming request
    always_comb begin
        sgn   = op_is_signed(bus.op);
        mag_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    end

    // One iteration: shift-add for multiply, restoring subtract for divide
    always_comb begin
        sum       = acc_q + (work_q[0] ? {1'b0, opnd_q} : '0);
        rem_shift = {acc_q, work_q[WIDTH-1]};
        diff      = rem_shift - {2'b00, opnd_q};
        if (op_is_div(op_q)) begin
            if (diff[WIDTH+1]) begin
                acc_step  = rem_shift[WIDTH:0];
                work_step = {work_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_step  = diff[WIDTH:0];
                work_step = {work_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_step  = {1'b0, sum[WIDTH:1]};
            work_step = {sum[0], work_q[WIDTH-1:1]};
        end
    end

    // Sign fix-up and divide-by-zero override applied in the final cycle
    always_comb begin
        prod     = {acc_q[WIDTH-1:0], work_q};
        prod_fix = res_neg_q ? -prod : prod;
        quo_fix  = res_neg_q ? -work_q : work_q;
        rem_fix  = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        if (!op_is_div(op_q)) begin
            {hi_fix, lo_fix} = prod_fix;
        end else if (b_zero_q) begin
            hi_fix = orig_a_q;
            lo_fix = '1;
        end else begin
            hi_fix = rem_fix;
            lo_fix = quo_fix;
        end
    end

    // FSM state and iteration counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: WIDTH iterations in CALC, then a single FIX cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(WIDTH)) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Datapath: capture on start, iterate in CALC, write HI/LO in FIX or on MTHI/MTLO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= MULT;
            opnd_q    <= '0;
            work_q    <= '0;
            acc_q     <= '0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            b_zero_q  <= 1'b0;
            orig_a_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start) begin
                        op_q      <= bus.op;
                        orig_a_q  <= bus.a;
                        b_zero_q  <= (bus.b == '0);
                        res_neg_q <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rem_neg_q <= sgn & bus.a[WIDTH-1];
                        acc_q     <= '0;
                        if (op_is_div(bus.op)) begin
                            opnd_q <= mag_b;
                            work_q <= mag_a;
                        end else begin
                            opnd_q <= mag_a;
                            work_q <= mag_b;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q  <= acc_step;
                    work_q <= work_step;
                end
                ST_FIX: begin
                    hi_q   <= hi_fix;
                    lo_q   <= lo_fix;
                    done_q <= 1'b1;
                    dbz_q  <= op_is_div(op_q) & b_zero_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH = 32).
module tb_mul_div_unit;
    import mips_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        muldiv_op_e  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, returns {dbz, hi, lo}
    function automatic logic [64:0] model(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            MULTU: p = {32'b0, a} * {32'b0, b};
            MULT:  p = 64'(sa * sb);
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (op == DIVU) begin
                    p = {a % b, a / b};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return {1'b0, p};
    endfunction

    // Waits for done, counting negedges since the start edge; bounded
    task automatic wait_done(input int cyc0, output int lat, output logic busy_ok);
        int cyc;
        cyc     = cyc0;
        busy_ok = 1'b1;
        while (!bus.done && cyc < 200) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        lat = cyc - 1;
    endtask

    task automatic do_op(input string nm, input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
        int   lat;
        logic busy_ok;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(1, lat, busy_ok);
        chk({nm, ".latency"}, 64'(lat), 64'(LAT));
        chk({nm, ".busy_held"}, 64'(busy_ok), 64'd1);
        chk({nm, ".busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({nm, ".hi"}, 64'(bus.hi), 64'(exp_hi));
        chk({nm, ".lo"}, 64'(bus.lo), 64'(exp_lo));
        chk({nm, ".dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        @(negedge clk);
        chk({nm, ".done_pulse"}, 64'({bus.done, bus.div_by_zero}), 64'd0);
    endtask

    initial begin
        int          lat;
        logic        busy_ok;
        logic [64:0] m;

        vecs[0]  = '{"multu_max",   MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{"mult_m3x7",   MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{"mult_minmin", MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{"div_m7_2",    DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4]  = '{"divu_7_2",    DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         1'b0};
        vecs[5]  = '{"div_ovf",     DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        vecs[6]  = '{"divu_7_0",    DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1};
        vecs[7]  = '{"div_m5_0",    DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{"multu_shift", MULTU, 32'h1234_5678, 32'h10,        32'd1,         32'h2345_6780, 1'b0};
        vecs[9]  = '{"div_100_m7",  DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0};
        vecs[10] = '{"divu_maxmax", DIVU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};
        vecs[11] = '{"divu_5_7",    DIVU,  32'd5,         32'd7,         32'd5,         32'd0,         1'b0};
        vecs[12] = '{"mult_m1m1",   MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset.state", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'd0);
        chk("reset.hilo", {bus.hi, bus.lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle.busy", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 13; i++)
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dbz);

        for (int i = 0; i < 120; i++) begin
            muldiv_op_e  rop;
            logic [31:0] ra, rb;
            rop = muldiv_op_e'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
                3: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            m = model(rop, ra, rb);
            do_op($sformatf("rand%0d", i), rop, ra, rb, m[63:32], m[31:0], m[64]);
        end

        // MTHI / MTLO while idle
        bus.hi_we = 1'b1;
        bus.wdata = 32'h1234_5678;
        @(negedge clk);
        bus.hi_we = 1'b0;
        chk("mthi_idle", 64'(bus.hi), 64'h1234_5678);
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0BAD_F00D;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo_idle", 64'(bus.lo), 64'h0BAD_F00D);

        // MTLO while busy is ignored
        bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd6; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.lo_we = 1'b0;
        chk("mtlo_busy_ignored", 64'(bus.lo), 64'h0BAD_F00D);
        wait_done(4, lat, busy_ok);
        chk("mtlo_busy.latency", 64'(lat), 64'(LAT));
        chk("mtlo_busy.result", {bus.hi, bus.lo}, 64'd42);
        @(negedge clk);

        // start while busy is ignored
        bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd3; bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd100; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(6, lat, busy_ok);
        chk("start_busy.latency", 64'(lat), 64'(LAT));
        chk("start_busy.result", {bus.hi, bus.lo}, 64'd15);
        @(negedge clk);
        chk("start_busy.not_queued", 64'(bus.busy), 64'd0);

        // start and MTHI in the same cycle, then back-to-back start in the done cycle
        bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd2; bus.b = 32'd3;
        bus.hi_we = 1'b1; bus.wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        chk("start_mthi.hi_written", 64'(bus.hi), 64'hCAFE_F00D);
        wait_done(1, lat, busy_ok);
        chk("start_mthi.latency", 64'(lat), 64'(LAT));
        chk("start_mthi.result", {bus.hi, bus.lo}, 64'd6);
        bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd7; bus.b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b.accepted", 64'(bus.busy), 64'd1);
        wait_done(1, lat, busy_ok);
        chk("b2b.latency", 64'(lat), 64'(LAT));
        chk("b2b.result", {bus.hi, bus.lo}, {32'd1, 32'd3});
        @(negedge clk);

        // reset in the middle of an operation
        bus.start = 1'b1; bus.op = DIVU; bus.a = 32'd1000; bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midreset.state", 64'({bus.busy, bus.done, bus.div_by_zero}), 64'd0);
        chk("midreset.hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op("post_reset", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers, for the MIPS-style single-cycle core. It executes MULT, MULTU, DIV and DIVU over a parametrised width and leaves the results in HI and LO. The core starts an operation with a start/busy/done handshake and reads HI/LO later for MFHI/MFLO. MTHI/MTLO writes are also supported. This replaces the combinational multiply path in the existing ALU.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 4 and even.
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- start  in  1  request an operation; accepted only when busy = 0.
- op  in  2  operation, a muldiv_op_e: MULT, MULTU, DIV, DIVU.
- a  in  WIDTH  multiplicand or dividend (rs).
- b  in  WIDTH  multiplier or divisor (rt).
- hi_we, lo_we  in  1 each  MTHI / MTLO write strobes.
- wdata  in  WIDTH  MTHI/MTLO data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  pulses with done when a DIV/DIVU had b = 0.
- hi, lo  out  WIDTH each  architectural HI/LO, registered.

## Operation
- FSM states:
  - IDLE → CALC on start.
  - CALC → FIX when the iteration counter reaches WIDTH.
  - FIX → IDLE unconditionally.
- On start, the unit captures:
  - op;
  - operand magnitudes (two's-complement absolute value for signed ops, raw for unsigned);
  - the result sign (a[W-1]^b[W-1]) and the remainder sign (a[W-1]), both signed ops only;
  - the original a;
  - b == 0.
- Multiply: radix-2 shift-add, one multiplier bit per CALC cycle, 2·WIDTH-bit product.
- Divide: restoring division, one quotient bit per CALC cycle.
  - Working remainder is WIDTH+1 bits.
  - The absolute value of the most-negative number is treated as an unsigned magnitude.
- FIX, multiply: {hi,lo} ← product, negated if the result sign is set.
- FIX, divide:
  - lo ← quotient, negated if the result sign is set.
  - hi ← remainder, negated if the remainder sign is set.
- FIX, divide by zero: lo ← all ones, hi ← original a, div_by_zero = 1. Latency is unchanged.
- Signed overflow (MIN / −1) gives lo = MIN, hi = 0, with no flag. This needs no special casing.
- MTHI/MTLO (hi_we/lo_we):
  - Honoured only when busy = 0; ignored while busy.
  - If start and a write arrive in the same cycle, the write takes effect; the later result overwrites it.
- start while busy is ignored. It is not queued.

## Timing
- Start accepted at edge E0. busy = 1 from E0.
- CALC iterations occur at E1..E_WIDTH.
- FIX at E_(WIDTH+1): hi/lo update, done = 1, busy = 0.
- Total latency is WIDTH+1 edges, i.e. 33 for WIDTH = 32.
- done and div_by_zero are high for exactly the cycle after E_(WIDTH+1).
- A new start may be asserted in the done cycle; it is accepted at the next edge.
- Reset, including mid-operation, immediately forces:
  - FSM = IDLE, counter = 0;
  - busy = 0, done = 0, div_by_zero = 0;
  - hi = 0, lo = 0.
- hi/lo change only at FIX, on an accepted MTHI/MTLO, or on reset.

## Structure
- Shared package mips_pkg holds:
  - the muldiv_op_e enum: MULT = 0, MULTU = 1, DIV = 2, DIVU = 3;
  - the funct constants 6'b011000–6'b011011 (mult/multu/div/divu) and 6'b010000–6'b010011 (mfhi/mthi/mflo/mtlo);
  - the FSM state typedef.
- Single module; no sub-module. Counter width is $clog2(WIDTH+1).

## Test plan
- MULTU a = 0xFFFFFFFF, b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; done exactly 33 edges after start; busy high throughout.
- MULT a = −3, b = 7 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- DIV a = −7, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 7 / 2 → lo = 3, hi = 1. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 7 / 0 → lo = 0xFFFFFFFF, hi = 7, div_by_zero pulses with done. DIV −5 / 0 → hi = 0xFFFFFFFB.
- start with new operands at cycle 5 of a busy operation → ignored, first result unchanged. Reset at cycle 10 → busy = 0, hi = lo = 0 immediately. A following start completes normally.
- hi_we with wdata = 0x12345678 while idle → hi = 0x12345678 next edge. lo_we while busy → lo unchanged. Start plus hi_we in the same cycle → hi shows wdata, then the result at done.
